// File: rtl/intlv_pkg.sv
// ============================================================================
//  Package     : intlv_pkg
//  Description : Shared constants and types for the turbo-interleaver address
//                counter: address width, the two block lengths with their QPP
//                coefficients, the initial QPP increments and the per-step
//                increment deltas.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package intlv_pkg;

  localparam int AW = 13;

  typedef logic [AW-1:0] addr_t;

  // Address mode latched on restart
  typedef enum logic {
    MODE_LIN = 1'b0,
    MODE_QPP = 1'b1
  } mode_e;

  localparam addr_t K0   = addr_t'(1056);
  localparam addr_t F1_0 = addr_t'(17);
  localparam addr_t F2_0 = addr_t'(66);
  localparam addr_t K1   = addr_t'(6144);
  localparam addr_t F1_1 = addr_t'(263);
  localparam addr_t F2_1 = addr_t'(480);

  // pi(1)-pi(0) = F1+F2 is the first increment; each step the increment
  // itself grows by 2*F2. All values are already reduced below K.
  localparam addr_t G0_0 = addr_t'(F1_0 + F2_0);
  localparam addr_t G0_1 = addr_t'(F1_1 + F2_1);
  localparam addr_t D0   = addr_t'(2 * F2_0);
  localparam addr_t D1   = addr_t'(2 * F2_1);

endpackage

`default_nettype wire

// File: rtl/qpp_mod_add.sv
// ============================================================================
//  Module      : qpp_mod_add
//  Description : Combinational modular adder, o_sum = (i_a + i_b) mod i_k,
//                valid when i_a < i_k and i_b < i_k (one conditional subtract).
//  Ports       : i_a, i_b  - addends (W bits, each < i_k)
//                i_k       - modulus (W bits)
//                o_sum     - reduced sum (W bits)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qpp_mod_add #(
  parameter int W = 13
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_k,
  output logic [W-1:0] o_sum
);

  logic [W:0]   w_sum;
  logic [W-1:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // The reduced result always fits in W bits, so the subtraction can be
  // done at W bits and simply wrap.
  assign w_diff = w_sum[W-1:0] - i_k;
  assign o_sum  = (w_sum >= {1'b0, i_k}) ? w_diff : w_sum[W-1:0];

endmodule

`default_nettype wire

// File: rtl/intlv_addr_ctr.sv
// ============================================================================
//  Module      : intlv_addr_ctr
//  Description : Address generator for one ping-pong RAM of the turbo
//                interleaver. Mode 0 emits linear addresses 0..K-1, mode 1
//                emits QPP addresses pi(i) = (F1*i + F2*i^2) mod K computed
//                recursively with two modular adds per step.
//  Ports       : clk         - clock, posedge
//                reset       - synchronous active-high reset
//                ctr_re      - restart; latches block_size and ctr_blk
//                ctr_en      - advance one address
//                ctr_blk     - 0 = linear, 1 = QPP
//                block_size  - 0 = K0, 1 = K1
//                addr        - current RAM address
//                count       - current index i
//                ctr_finish  - high while count == K-1
//  Config      : INTLV_ADDR_REG_EN - adds one register stage on addr and
//                ctr_finish (count is not delayed)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module intlv_addr_ctr
  import intlv_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          ctr_re,
  input  logic          ctr_en,
  input  logic          ctr_blk,
  input  logic          block_size,
  output logic [AW-1:0] addr,
  output logic [AW-1:0] count,
  output logic          ctr_finish
);

  addr_t r_cnt;
  addr_t r_adr;
  addr_t r_g;
  logic  r_ksel;
  mode_e r_mode;

  addr_t w_k;
  addr_t w_g0;
  addr_t w_d;
  addr_t w_adr_nxt;
  addr_t w_g_nxt;
  addr_t w_cnt_inc;
  logic  w_last;

  // Block constants follow the latched selection, not the live input
  assign w_k       = r_ksel ? K1 : K0;
  assign w_g0      = r_ksel ? G0_1 : G0_0;
  assign w_d       = r_ksel ? D1 : D0;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_last    = (r_cnt == (w_k - 1'b1));

  qpp_mod_add #(.W(AW)) u_add_adr (
    .i_a   (r_adr),
    .i_b   (r_g),
    .i_k   (w_k),
    .o_sum (w_adr_nxt)
  );

  qpp_mod_add #(.W(AW)) u_add_g (
    .i_a   (r_g),
    .i_b   (w_d),
    .i_k   (w_k),
    .o_sum (w_g_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_adr  <= '0;
      r_g    <= G0_0;
      r_ksel <= 1'b0;
      r_mode <= MODE_LIN;
    end else if (ctr_re) begin
      r_cnt  <= '0;
      r_adr  <= '0;
      r_g    <= block_size ? G0_1 : G0_0;
      r_ksel <= block_size;
      r_mode <= mode_e'(ctr_blk);
    end else if (ctr_en) begin
      if (w_last) begin
        // Roll straight into the next block with no idle cycle
        r_cnt <= '0;
        r_adr <= '0;
        r_g   <= w_g0;
      end else begin
        r_cnt <= w_cnt_inc;
        if (r_mode == MODE_QPP) begin
          r_adr <= w_adr_nxt;
          r_g   <= w_g_nxt;
        end else begin
          r_adr <= w_cnt_inc;
        end
      end
    end
  end

  assign count = r_cnt;

`ifdef INTLV_ADDR_REG_EN
  addr_t r_addr_q;
  logic  r_fin_q;

  always_ff @(posedge clk) begin
    if (reset || ctr_re) begin
      r_addr_q <= '0;
      r_fin_q  <= 1'b0;
    end else begin
      r_addr_q <= r_adr;
      r_fin_q  <= w_last;
    end
  end

  assign addr       = r_addr_q;
  assign ctr_finish = r_fin_q;
`else
  assign addr       = r_adr;
  assign ctr_finish = w_last;
`endif

endmodule

`default_nettype wire

// File: tb/tb_intlv_addr_ctr.sv
// ============================================================================
//  Module      : tb_intlv_addr_ctr
//  Description : Self-checking bench for intlv_addr_ctr. A reference model
//                tracks the index and latched block settings and derives the
//                expected address directly from pi(i) = (F1*i + F2*i^2) mod K.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_intlv_addr_ctr;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ctr_re = 1'b0;
  logic        ctr_en = 1'b0;
  logic        ctr_blk = 1'b0;
  logic        block_size = 1'b0;
  logic [12:0] addr;
  logic [12:0] count;
  logic        ctr_finish;

  int n_chk = 0;
  int n_err = 0;

  // Model state
  int m_cnt  = 0;
  int m_ksel = 0;
  int m_mode = 0;

  bit seen [0:6143];

`ifdef INTLV_ADDR_REG_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif

  always #5 clk = ~clk;

  intlv_addr_ctr dut (
    .clk        (clk),
    .reset      (reset),
    .ctr_re     (ctr_re),
    .ctr_en     (ctr_en),
    .ctr_blk    (ctr_blk),
    .block_size (block_size),
    .addr       (addr),
    .count      (count),
    .ctr_finish (ctr_finish)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int k_of(input int ks);
    return ks ? 6144 : 1056;
  endfunction

  function automatic int pi(input int ks, input int i);
    longint k, f1, f2, t;
    k  = ks ? 6144 : 1056;
    f1 = ks ? 263 : 17;
    f2 = ks ? 480 : 66;
    t  = (f1 * i + f2 * i * i) % k;
    return int'(t);
  endfunction

  function automatic int m_addr();
    return m_mode ? pi(m_ksel, m_cnt) : m_cnt;
  endfunction

  function automatic int m_fin();
    return (m_cnt == k_of(m_ksel) - 1) ? 1 : 0;
  endfunction

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // One clock: drive inputs, advance the model, then compare outputs.
  task automatic cyc(input bit rst, input bit re, input bit en, input bit bs, input bit blk);
    int p_addr, p_fin, e_addr, e_fin;
    reset = rst; ctr_re = re; ctr_en = en; block_size = bs; ctr_blk = blk;
    @(posedge clk);
    p_addr = m_addr();
    p_fin  = m_fin();
    if (rst) begin
      m_cnt = 0; m_ksel = 0; m_mode = 0;
    end else if (re) begin
      m_cnt = 0; m_ksel = bs; m_mode = blk;
    end else if (en) begin
      m_cnt = (m_cnt == k_of(m_ksel) - 1) ? 0 : m_cnt + 1;
    end
    if (LAG != 0) begin
      e_addr = (rst || re) ? 0 : p_addr;
      e_fin  = (rst || re) ? 0 : p_fin;
    end else begin
      e_addr = m_addr();
      e_fin  = m_fin();
    end
    #1;
    check("count", int'(count), m_cnt);
    check("addr", int'(addr), e_addr);
    check("finish", int'(ctr_finish), e_fin);
  endtask

  // Restart in QPP mode and confirm the block is a permutation with the
  // expected leading and trailing addresses.
  task automatic qpp_block(input bit bs, input int a1, input int a2, input int alast);
    int k, ndist, idx;
    k = k_of(bs);
    for (int j = 0; j < 6144; j++) seen[j] = 1'b0;
    ndist = 0;
    cyc(0, 1, 0, bs, 1);
    for (int j = 0; j < k + LAG; j++) begin
      idx = j;
      if (j > 0) cyc(0, 0, 1, rb(), rb());
      if (idx >= LAG) begin
        idx = idx - LAG;
        if (idx == 1) check("qpp_a1", int'(addr), a1);
        if (idx == 2) check("qpp_a2", int'(addr), a2);
        if (idx == k - 1) begin
          check("qpp_last", int'(addr), alast);
          check("qpp_last_fin", int'(ctr_finish), 1);
        end
        if (int'(addr) < k) begin
          if (seen[addr]) check("perm_dup", int'(addr), -1);
          else begin
            seen[addr] = 1'b1;
            ndist++;
          end
        end else begin
          check("perm_range", int'(addr), k - 1);
        end
      end
    end
    check("perm_cnt", ndist, k);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
  endtask

  initial begin
    int guard;

    // T1: reset dominates a held enable
    for (int j = 0; j < 4; j++) cyc(1, 0, 1, rb(), rb());

    // T2: linear block of K0 and wrap
    cyc(0, 1, 0, 0, 0);
    for (int j = 0; j < 1056 + 3; j++) begin
      cyc(0, 0, 1, rb(), rb());
      if (LAG == 0 && j == 1054) check("lin_last", int'(addr), 1055);
    end

    // T3 / T4: QPP blocks for both lengths
    qpp_block(0, 83, 298, 49);
    qpp_block(1, 743, 2446, 217);

    // T5: mid-block restart, select changed without restart is ignored
    cyc(0, 1, 0, 0, 1);
    for (int j = 0; j < 500; j++) cyc(0, 0, 1, 0, 1);
    check("t5_count500", int'(count), 500);
    for (int j = 0; j < 5; j++) cyc(0, 0, $urandom_range(0, 1) == 1, 1, rb());
    cyc(0, 1, 1, 0, 1);
    check("t5_restart_cnt", int'(count), 0);
    check("t5_restart_adr", int'(addr), 0);
    // Hold block_size=1 without restart: block length must stay K0
    for (int j = 0; j < 1056 + 4; j++) cyc(0, 0, 1, 1, 0);

    // T6: random enable gaps in QPP mode, pause at K-1
    cyc(0, 1, 0, 0, 1);
    guard = 0;
    while (m_cnt != 1055 && guard < 5000) begin
      cyc(0, 0, rb(), rb(), rb());
      guard++;
    end
    check("t6_reach_last", m_cnt, 1055);
    for (int j = 0; j < 4; j++) cyc(0, 0, 0, rb(), rb());
    check("t6_pause_fin", int'(ctr_finish), 1);
    check("t6_pause_adr", int'(addr), 49);
    for (int j = 0; j < 6; j++) cyc(0, 0, rb(), rb(), rb());

    // Reset again mid-run
    cyc(1, 0, 1, 1, 1);
    cyc(0, 0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
